// File: rtl/router_port.sv
`default_nettype none
// =============================================================================
// router_port : router-side endpoint of the byte-serial node<->router link
// Revision    : 1.0
// =============================================================================
module router_port #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        put_from_node,
    input  logic [7:0]  payload_from_node,
    output logic        free_to_node,
    output logic [31:0] pkt_to_router,
    output logic [3:0]  pkt_to_router_dest,
    output logic        pkt_to_router_valid,
    input  logic        pkt_to_router_ready,
    input  logic [31:0] pkt_from_router,
    input  logic        pkt_from_router_valid,
    output logic        pkt_from_router_ready,
    input  logic        free_from_node,
    output logic        put_to_node,
    output logic [7:0]  payload_to_node,
    output logic        err_overflow
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_OCC_W = $clog2(DEPTH + 1);

    // ---------------------------------------------------------------- receive
    logic [1:0]         r_rx_cnt;
    logic [23:0]        r_partial;
    logic [31:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_occ;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_write;
    logic               w_drop;
    logic [1:0]         w_rx_cnt_next;
    logic [c_OCC_W-1:0] w_occ_next;
    logic [c_OCC_W:0]   w_reserved;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign w_push        = put_from_node && (r_rx_cnt == 2'd3);
    assign w_pop         = pkt_to_router_valid && pkt_to_router_ready;
    assign w_full        = (r_occ == c_OCC_W'(DEPTH));
    assign w_write       = w_push && (!w_full || w_pop);
    assign w_drop        = w_push && w_full && !w_pop;
    assign w_rx_cnt_next = put_from_node ? (r_rx_cnt + 2'd1) : r_rx_cnt;

    always_comb begin
        w_occ_next = r_occ;
        if (w_write && !w_pop) begin
            w_occ_next = r_occ + c_OCC_W'(1);
        end else if (!w_write && w_pop) begin
            w_occ_next = r_occ - c_OCC_W'(1);
        end
    end

    // Count an in-flight packet as occupying a slot so the node can start
    // the next packet straight after sampling free on its last byte.
    assign w_reserved = {1'b0, w_occ_next} + (c_OCC_W + 1)'(w_rx_cnt_next != 2'd0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rx_cnt     <= '0;
            r_partial    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            free_to_node <= 1'b1;
            err_overflow <= 1'b0;
        end else begin
            r_rx_cnt     <= w_rx_cnt_next;
            if (put_from_node) begin
                r_partial <= {r_partial[15:0], payload_from_node};
            end
            if (w_write) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_occ        <= w_occ_next;
            free_to_node <= (w_reserved < (c_OCC_W + 1)'(DEPTH));
            if (w_drop) begin
                err_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {r_partial, payload_from_node};
        end
    end

    assign pkt_to_router_valid = (r_occ != '0);
    assign pkt_to_router       = pkt_to_router_valid ? r_mem[r_rd_ptr] : 32'h0;
    assign pkt_to_router_dest  = pkt_to_router[27:24];

    // --------------------------------------------------------------- transmit
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } tx_state_t;

    tx_state_t   r_state;
    logic        r_hold_valid;
    logic [31:0] r_hold;
    logic [31:0] r_tx_sh;
    logic [1:0]  r_tx_cnt;
    logic        w_accept;
    logic        w_launch;

    assign w_accept = pkt_from_router_valid && !r_hold_valid;
    assign w_launch = r_hold_valid && free_from_node &&
                      ((r_state == S_IDLE) || (r_tx_cnt == 2'd3));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= S_IDLE;
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
            r_tx_sh      <= '0;
            r_tx_cnt     <= '0;
        end else begin
            // accept and launch are exclusive: one needs the hold empty, the other full
            if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_hold       <= pkt_from_router;
            end else if (w_launch) begin
                r_hold_valid <= 1'b0;
            end

            if (w_launch) begin
                r_state  <= S_SEND;
                r_tx_sh  <= r_hold;
                r_tx_cnt <= 2'd0;
            end else if (r_state == S_SEND) begin
                if (r_tx_cnt == 2'd3) begin
                    r_state  <= S_IDLE;
                    r_tx_sh  <= '0;
                    r_tx_cnt <= 2'd0;
                end else begin
                    r_tx_sh  <= {r_tx_sh[23:0], 8'h00};
                    r_tx_cnt <= r_tx_cnt + 2'd1;
                end
            end
        end
    end

    assign put_to_node           = (r_state == S_SEND);
    assign payload_to_node       = r_tx_sh[31:24];
    assign pkt_from_router_ready = !r_hold_valid;

endmodule
`default_nettype wire

// File: tb/tb_router_port.sv
`default_nettype none
// tb_router_port: vector table, directed corner sequences and a randomized run
// checked against a queue-based model of the link and buffer rules.
module tb_router_port;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        put_from_node;
    logic [7:0]  payload_from_node;
    logic        free_to_node;
    logic [31:0] pkt_to_router;
    logic [3:0]  pkt_to_router_dest;
    logic        pkt_to_router_valid;
    logic        pkt_to_router_ready;
    logic [31:0] pkt_from_router;
    logic        pkt_from_router_valid;
    logic        pkt_from_router_ready;
    logic        free_from_node;
    logic        put_to_node;
    logic [7:0]  payload_to_node;
    logic        err_overflow;

    router_port #(.DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .rst_b                 (rst_b),
        .put_from_node         (put_from_node),
        .payload_from_node     (payload_from_node),
        .free_to_node          (free_to_node),
        .pkt_to_router         (pkt_to_router),
        .pkt_to_router_dest    (pkt_to_router_dest),
        .pkt_to_router_valid   (pkt_to_router_valid),
        .pkt_to_router_ready   (pkt_to_router_ready),
        .pkt_from_router       (pkt_from_router),
        .pkt_from_router_valid (pkt_from_router_valid),
        .pkt_from_router_ready (pkt_from_router_ready),
        .free_from_node        (free_from_node),
        .put_to_node           (put_to_node),
        .payload_to_node       (payload_to_node),
        .err_overflow          (err_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        put_from_node         = 1'b0;
        payload_from_node     = 8'h00;
        pkt_to_router_ready   = 1'b0;
        pkt_from_router       = 32'h0;
        pkt_from_router_valid = 1'b0;
        free_from_node        = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".valid"}, pkt_to_router_valid, 32'd0);
        chk({tag, ".pkt"}, pkt_to_router, 32'h0);
        chk({tag, ".free"}, free_to_node, 32'd1);
        chk({tag, ".err"}, err_overflow, 32'd0);
        chk({tag, ".put"}, put_to_node, 32'd0);
        chk({tag, ".payload"}, payload_to_node, 32'h0);
        chk({tag, ".ready"}, pkt_from_router_ready, 32'd1);
    endtask

    task automatic apply_reset();
        rst_b = 1'b0;
        set_idle();
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        step();
    endtask

    task automatic send_bytes(input logic [31:0] p, input logic rdy_last);
        for (int b = 0; b < 4; b++) begin
            put_from_node       = 1'b1;
            payload_from_node   = p[31-8*b -: 8];
            pkt_to_router_ready = (b == 3) ? rdy_last : 1'b0;
            step();
        end
        put_from_node       = 1'b0;
        payload_from_node   = 8'h00;
        pkt_to_router_ready = 1'b0;
    endtask

    // ------------------------------------------------ well-behaved node sender
    int          nd_byte;
    int          nd_sent;
    logic        nd_free_prev;
    logic [31:0] nd_cur;
    logic [31:0] sent_q[$];

    task automatic node_init();
        nd_byte      = 0;
        nd_sent      = 0;
        nd_free_prev = free_to_node;
        nd_cur       = 32'h0;
        sent_q.delete();
    endtask

    // Drives one cycle; a packet starts only if free was 1 in the previous cycle.
    task automatic node_drive(input int stall_pct, input int start_pct, input int max_pkts);
        logic go;
        logic free_now;
        free_now = free_to_node;
        go = 1'b0;
        if (nd_byte != 0) begin
            go = ($urandom_range(99) >= stall_pct);
        end else if (nd_free_prev && (nd_sent < max_pkts) && ($urandom_range(99) < start_pct)) begin
            go     = 1'b1;
            nd_cur = $urandom;
            sent_q.push_back(nd_cur);
        end
        nd_free_prev      = free_now;
        put_from_node     = go;
        payload_from_node = go ? nd_cur[31-8*nd_byte -: 8] : 8'h00;
        if (go) begin
            if (nd_byte == 3) begin
                nd_byte = 0;
                nd_sent++;
            end else begin
                nd_byte++;
            end
        end
    endtask

    // ------------------------------------------------------- reference model
    logic [31:0] m_rxq[$];
    logic [7:0]  m_part[$];
    logic        m_err;
    logic        m_free;
    logic        m_hv;
    logic [31:0] m_hold;
    logic [31:0] m_cur;
    int          m_rem;     // bytes of m_cur still to appear on the link

    task automatic model_reset();
        m_rxq.delete();
        m_part.delete();
        m_err  = 1'b0;
        m_free = 1'b1;
        m_hv   = 1'b0;
        m_hold = 32'h0;
        m_cur  = 32'h0;
        m_rem  = 0;
    endtask

    task automatic model_step();
        logic        accept;
        logic [31:0] p;
        if ((m_rxq.size() > 0) && pkt_to_router_ready) void'(m_rxq.pop_front());
        if (put_from_node) begin
            m_part.push_back(payload_from_node);
            if (m_part.size() == 4) begin
                p = {m_part[0], m_part[1], m_part[2], m_part[3]};
                m_part.delete();
                if (m_rxq.size() < DEPTH) m_rxq.push_back(p);
                else m_err = 1'b1;
            end
        end
        m_free = ((m_rxq.size() + ((m_part.size() != 0) ? 1 : 0)) < DEPTH);

        accept = pkt_from_router_valid && !m_hv;
        if ((m_rem <= 1) && m_hv && free_from_node) begin
            m_cur = m_hold;
            m_rem = 4;
            m_hv  = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        if (accept) begin
            m_hv   = 1'b1;
            m_hold = pkt_from_router;
        end
    endtask

    // ---------------------------------------------------------- vector table
    typedef struct {
        logic        put;
        logic [7:0]  byte_in;
        logic        rdy;
        logic [31:0] tx_pkt;
        logic        tx_valid;
        logic        node_free;
        logic        exp_valid;
        logic [31:0] exp_pkt;
        logic        exp_free;
        logic        exp_put;
        logic [7:0]  exp_byte;
        logic        exp_ready;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] exp_q[$];
    logic [31:0] txa;
    logic [31:0] txb;
    logic [63:0] txab;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // single receive 0x12345678, then pop
        vecs[0]  = '{1'b1, 8'h12, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[1]  = '{1'b1, 8'h34, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[2]  = '{1'b1, 8'h56, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[3]  = '{1'b1, 8'h78, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b1};
        // single transmit 0xA5C30F01
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 32'hA5C30F01, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 8'hA5, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 8'hC3, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 8'h0F, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 8'h01, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b1};

        rst_b = 1'b0;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst_hold");
        @(negedge clk);
        rst_b = 1'b1;
        step();
        chk_reset_vals("rst_rel");

        for (int i = 0; i < 11; i++) begin
            put_from_node         = vecs[i].put;
            payload_from_node     = vecs[i].byte_in;
            pkt_to_router_ready   = vecs[i].rdy;
            pkt_from_router       = vecs[i].tx_pkt;
            pkt_from_router_valid = vecs[i].tx_valid;
            free_from_node        = vecs[i].node_free;
            step();
            chk($sformatf("vec%0d.valid", i), pkt_to_router_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d.pkt", i), pkt_to_router, vecs[i].exp_pkt);
            chk($sformatf("vec%0d.dest", i), pkt_to_router_dest, vecs[i].exp_pkt[27:24]);
            chk($sformatf("vec%0d.free", i), free_to_node, vecs[i].exp_free);
            chk($sformatf("vec%0d.put", i), put_to_node, vecs[i].exp_put);
            if (vecs[i].exp_put) chk($sformatf("vec%0d.payload", i), payload_to_node, vecs[i].exp_byte);
            chk($sformatf("vec%0d.ready", i), pkt_from_router_ready, vecs[i].exp_ready);
        end
        set_idle();

        // fill: node obeys free, router core never ready
        node_init();
        for (int c = 0; c < 30; c++) begin
            node_drive(0, 100, 100);
            pkt_to_router_ready = 1'b0;
            step();
        end
        set_idle();
        chk("fill.sent", nd_sent, 32'd4);
        chk("fill.partial", nd_byte, 32'd0);
        chk("fill.free", free_to_node, 32'd0);
        chk("fill.err", err_overflow, 32'd0);
        chk("fill.head", pkt_to_router, sent_q[0]);
        exp_q = sent_q;

        pkt_to_router_ready = 1'b1;
        step();
        pkt_to_router_ready = 1'b0;
        void'(exp_q.pop_front());
        chk("pop1.free", free_to_node, 32'd1);
        chk("pop1.head", pkt_to_router, exp_q[0]);

        send_bytes(32'h4E0A_1B2C, 1'b0);
        exp_q.push_back(32'h4E0A_1B2C);
        chk("refill.free", free_to_node, 32'd0);
        chk("refill.err", err_overflow, 32'd0);

        // push and pop together while full
        send_bytes(32'h7F00_BEEF, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(32'h7F00_BEEF);
        chk("pushpop.err", err_overflow, 32'd0);
        chk("pushpop.valid", pkt_to_router_valid, 32'd1);
        chk("pushpop.head", pkt_to_router, exp_q[0]);
        chk("pushpop.free", free_to_node, 32'd0);

        // forced push at full without pop
        send_bytes(32'h3C3C_5A5A, 1'b0);
        chk("ovf.err", err_overflow, 32'd1);
        chk("ovf.head", pkt_to_router, exp_q[0]);

        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d.head", i), pkt_to_router, exp_q[i]);
            pkt_to_router_ready = 1'b1;
            step();
        end
        pkt_to_router_ready = 1'b0;
        chk("drain.empty", pkt_to_router_valid, 32'd0);
        chk("drain.err_sticky", err_overflow, 32'd1);

        // transmit stall, then two back-to-back packets
        txa  = 32'hDEADBEEF;
        txb  = 32'h0BADF00D;
        txab = {txa, txb};
        free_from_node        = 1'b0;
        pkt_from_router       = txa;
        pkt_from_router_valid = 1'b1;
        step();
        pkt_from_router       = txb;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("stall%0d.put", c), put_to_node, 32'd0);
            chk($sformatf("stall%0d.ready", c), pkt_from_router_ready, 32'd0);
            if (c < 3) step();
        end
        free_from_node = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pkt_from_router_valid = (k <= 1);
            step();
            chk($sformatf("b2b%0d.put", k), put_to_node, 32'd1);
            chk($sformatf("b2b%0d.payload", k), payload_to_node, txab[63-8*k -: 8]);
        end
        pkt_from_router_valid = 1'b0;
        step();
        chk("b2b.end_put", put_to_node, 32'd0);
        chk("b2b.end_ready", pkt_from_router_ready, 32'd1);

        // reset mid-packet in both directions with a packet buffered
        send_bytes(32'hC0FF_EE01, 1'b0);
        put_from_node         = 1'b1;
        payload_from_node     = 8'hAB;
        pkt_from_router       = 32'h1357_9BDF;
        pkt_from_router_valid = 1'b1;
        free_from_node        = 1'b1;
        step();
        payload_from_node     = 8'hCD;
        pkt_from_router_valid = 1'b0;
        step();
        chk("midrst.pre_put", put_to_node, 32'd1);
        chk("midrst.pre_valid", pkt_to_router_valid, 32'd1);
        rst_b = 1'b0;
        set_idle();
        #2;
        chk_reset_vals("midrst.in");
        @(negedge clk);
        rst_b = 1'b1;
        step();
        chk_reset_vals("midrst.out");
        send_bytes(32'h9A3B_5C7D, 1'b0);
        chk("fresh.valid", pkt_to_router_valid, 32'd1);
        chk("fresh.pkt", pkt_to_router, 32'h9A3B_5C7D);
        chk("fresh.dest", pkt_to_router_dest, 32'hA);

        // randomized traffic against the model
        apply_reset();
        model_reset();
        node_init();
        for (int c = 0; c < 2000; c++) begin
            node_drive(10, 60, 1000000);
            pkt_to_router_ready   = ($urandom_range(99) < 40);
            pkt_from_router_valid = ($urandom_range(99) < 50);
            pkt_from_router       = $urandom;
            free_from_node        = ($urandom_range(99) < 70);
            model_step();
            step();
            chk("rnd.free", free_to_node, m_free);
            chk("rnd.valid", pkt_to_router_valid, (m_rxq.size() != 0));
            if (m_rxq.size() != 0) begin
                chk("rnd.pkt", pkt_to_router, m_rxq[0]);
                chk("rnd.dest", pkt_to_router_dest, m_rxq[0][27:24]);
            end
            chk("rnd.err", err_overflow, m_err);
            chk("rnd.ready", pkt_from_router_ready, !m_hv);
            chk("rnd.put", put_to_node, (m_rem != 0));
            if (m_rem != 0) chk("rnd.payload", payload_to_node, m_cur[8*m_rem-1 -: 8]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
